corr_matrix_acc: RTL and testbench

//  Accumulates the 2x2 spatial covariance matrix of two antenna streams for DoA estimation.

---
 rtl/corr_pkg.sv | 19 +
 rtl/corr_mac.sv | 101 ++++++++++
 rtl/corr_matrix_acc.sv | 93 +++++++++
 tb/tb_corr_matrix_acc.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared constants for the covariance accumulator: default widths, derived
// product/accumulator widths, convert shift and output saturation limits.
package corr_pkg;

    localparam int DIN_WIDTH_DEF    = 16;
    localparam int DIN_POINT_DEF    = 15;
    localparam int ACC_LEN_LOG2_DEF = 10;
    localparam int DOUT_WIDTH_DEF   = 16;
    localparam int DOUT_POINT_DEF   = 15;

    localparam int PROD_WIDTH = 2 * DIN_WIDTH_DEF;
    localparam int ACC_WIDTH  = PROD_WIDTH + ACC_LEN_LOG2_DEF;
    localparam int SHIFT      = 2 * DIN_POINT_DEF - DOUT_POINT_DEF;

    localparam logic [DOUT_WIDTH_DEF-1:0] USAT_MAX = {DOUT_WIDTH_DEF{1'b1}};
    localparam logic [DOUT_WIDTH_DEF-1:0] SSAT_MAX = {1'b0, {(DOUT_WIDTH_DEF-1){1'b1}}};
    localparam logic [DOUT_WIDTH_DEF-1:0] SSAT_MIN = {1'b1, {(DOUT_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/corr_mac.sv
// One product/accumulate lane: registers a*b, accumulates valid products,
// and on the frame's last product converts the frame sum to a saturated mean.
module corr_mac
    import corr_pkg::*;
#(
    parameter bit SIGNED       = 1'b1,
    parameter int DIN_WIDTH    = DIN_WIDTH_DEF,
    parameter int DIN_POINT    = DIN_POINT_DEF,
    parameter int ACC_LEN_LOG2 = ACC_LEN_LOG2_DEF,
    parameter int DOUT_WIDTH   = DOUT_WIDTH_DEF,
    parameter int DOUT_POINT   = DOUT_POINT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  acc_en,
    input  logic                  dump,
    input  logic [DIN_WIDTH-1:0]  a,
    input  logic [DIN_WIDTH-1:0]  b,
    output logic [DOUT_WIDTH-1:0] dout
);

    localparam int PW  = 2 * DIN_WIDTH;
    localparam int AW  = PW + ACC_LEN_LOG2;
    localparam int TOT = ACC_LEN_LOG2 + 2 * DIN_POINT - DOUT_POINT;

    logic signed [PW-1:0] a_ext_s;
    logic signed [PW-1:0] b_ext_s;
    logic signed [PW-1:0] prod_r;
    logic [AW-1:0]        prod_ext_s;
    logic [AW-1:0]        sum_s;
    logic [AW-1:0]        shifted_s;
    logic [AW-DOUT_WIDTH:0] upper_s;
    logic [DOUT_WIDTH-1:0] sat_s;
    logic [AW-1:0]        acc_r;
    logic [DOUT_WIDTH-1:0] dout_r;

    assign a_ext_s = {{DIN_WIDTH{a[DIN_WIDTH-1]}}, a};
    assign b_ext_s = {{DIN_WIDTH{b[DIN_WIDTH-1]}}, b};

    // Extend the product, add it to the running sum, scale and saturate it.
    // Squares are never negative, so the unsigned lanes zero-extend.
    always_comb begin
        prod_ext_s = '0;
        shifted_s  = '0;
        sat_s      = '0;
        if (SIGNED) begin
            prod_ext_s = {{ACC_LEN_LOG2{prod_r[PW-1]}}, prod_r};
        end else begin
            prod_ext_s = {{ACC_LEN_LOG2{1'b0}}, prod_r};
        end
        sum_s = acc_r + prod_ext_s;
        if (SIGNED) begin
            shifted_s = AW'($signed(sum_s) >>> TOT);
        end else begin
            shifted_s = sum_s >> TOT;
        end
        upper_s = shifted_s[AW-1:DOUT_WIDTH-1];
        if (SIGNED) begin
            if ((upper_s == '0) || (upper_s == '1)) begin
                sat_s = shifted_s[DOUT_WIDTH-1:0];
            end else if (shifted_s[AW-1]) begin
                sat_s = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
            end else begin
                sat_s = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            end
        end else begin
            if (|shifted_s[AW-1:DOUT_WIDTH]) begin
                sat_s = {DOUT_WIDTH{1'b1}};
            end else begin
                sat_s = shifted_s[DOUT_WIDTH-1:0];
            end
        end
    end

    // Product register, accumulator (cleared on dump or sync) and held output.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r <= '0;
            acc_r  <= '0;
            dout_r <= '0;
        end else begin
            prod_r <= a_ext_s * b_ext_s;
            if (dump) begin
                dout_r <= sat_s;
            end else begin
                dout_r <= dout_r;
            end
            if (clr || dump) begin
                acc_r <= '0;
            end else if (acc_en) begin
                acc_r <= sum_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/corr_matrix_acc.sv
// 2x2 spatial covariance accumulator: input registers, frame counter,
// sync/reset handling and the dout_valid pulse around three MAC lanes.
module corr_matrix_acc
    import corr_pkg::*;
#(
    parameter int DIN_WIDTH    = DIN_WIDTH_DEF,
    parameter int DIN_POINT    = DIN_POINT_DEF,
    parameter int ACC_LEN_LOG2 = ACC_LEN_LOG2_DEF,
    parameter int DOUT_WIDTH   = DOUT_WIDTH_DEF,
    parameter int DOUT_POINT   = DOUT_POINT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_WIDTH-1:0]  din1,
    input  logic [DIN_WIDTH-1:0]  din2,
    input  logic                  din_valid,
    input  logic                  sync,
    output logic [DOUT_WIDTH-1:0] r11,
    output logic [DOUT_WIDTH-1:0] r22,
    output logic [DOUT_WIDTH-1:0] r12,
    output logic                  dout_valid
);

    localparam logic [ACC_LEN_LOG2-1:0] CNT_ONE  = {{(ACC_LEN_LOG2-1){1'b0}}, 1'b1};
    localparam logic [ACC_LEN_LOG2-1:0] CNT_LAST = {ACC_LEN_LOG2{1'b1}};

    logic [DIN_WIDTH-1:0]    d1_r;
    logic [DIN_WIDTH-1:0]    d2_r;
    logic                    v1_r;
    logic                    v2_r;
    logic [ACC_LEN_LOG2-1:0] cnt_r;
    logic                    dout_valid_r;
    logic                    last_s;

    // The last product of a frame is in S2 and about to be accumulated.
    assign last_s = v2_r && (cnt_r == CNT_LAST);

    // S1 capture, S2 valid, frame counter and output pulse. A sample arriving
    // with sync is kept as sample 0; everything already in flight is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1_r         <= '0;
            d2_r         <= '0;
            v1_r         <= 1'b0;
            v2_r         <= 1'b0;
            cnt_r        <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            d1_r         <= din1;
            d2_r         <= din2;
            v1_r         <= din_valid;
            dout_valid_r <= last_s;
            if (sync) begin
                v2_r  <= 1'b0;
                cnt_r <= '0;
            end else begin
                v2_r <= v1_r;
                if (v2_r) begin
                    cnt_r <= cnt_r + CNT_ONE;
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end
    end

    corr_mac #(
        .SIGNED(1'b0), .DIN_WIDTH(DIN_WIDTH), .DIN_POINT(DIN_POINT),
        .ACC_LEN_LOG2(ACC_LEN_LOG2), .DOUT_WIDTH(DOUT_WIDTH), .DOUT_POINT(DOUT_POINT)
    ) u_mac11 (
        .clk(clk), .rst(rst), .clr(sync), .acc_en(v2_r), .dump(last_s),
        .a(d1_r), .b(d1_r), .dout(r11)
    );

    corr_mac #(
        .SIGNED(1'b0), .DIN_WIDTH(DIN_WIDTH), .DIN_POINT(DIN_POINT),
        .ACC_LEN_LOG2(ACC_LEN_LOG2), .DOUT_WIDTH(DOUT_WIDTH), .DOUT_POINT(DOUT_POINT)
    ) u_mac22 (
        .clk(clk), .rst(rst), .clr(sync), .acc_en(v2_r), .dump(last_s),
        .a(d2_r), .b(d2_r), .dout(r22)
    );

    corr_mac #(
        .SIGNED(1'b1), .DIN_WIDTH(DIN_WIDTH), .DIN_POINT(DIN_POINT),
        .ACC_LEN_LOG2(ACC_LEN_LOG2), .DOUT_WIDTH(DOUT_WIDTH), .DOUT_POINT(DOUT_POINT)
    ) u_mac12 (
        .clk(clk), .rst(rst), .clr(sync), .acc_en(v2_r), .dump(last_s),
        .a(d1_r), .b(d2_r), .dout(r12)
    );

    assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_corr_matrix_acc.sv
// Scoreboard bench for corr_matrix_acc with N=4: directed frames plus random
// traffic, checked against a frame-level reference model.
module tb_corr_matrix_acc;

    localparam int L    = 2;
    localparam int N    = 1 << L;
    localparam int TOT  = L + 15;

    typedef struct {
        logic [15:0] r11;
        logic [15:0] r22;
        logic [15:0] r12;
        longint      due;
    } exp_t;

    typedef struct {
        int     x1;
        int     x2;
        longint commit;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din1 = 16'h0000;
    logic [15:0] din2 = 16'h0000;
    logic        din_valid = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] r11, r22, r12;
    logic        dout_valid;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    bit     mon_en   = 1'b0;

    exp_t exp_q[$];
    smp_t pend_q[$];
    int   f1_q[$];
    int   f2_q[$];
    logic [15:0] hold11 = 16'h0000, hold22 = 16'h0000, hold12 = 16'h0000;

    corr_matrix_acc #(
        .DIN_WIDTH(16), .DIN_POINT(15), .ACC_LEN_LOG2(L),
        .DOUT_WIDTH(16), .DOUT_POINT(15)
    ) dut (
        .clk(clk), .rst(rst), .din1(din1), .din2(din2), .din_valid(din_valid),
        .sync(sync), .r11(r11), .r22(r22), .r12(r12), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mean_u(input longint sum);
        longint m;
        m = sum >>> TOT;
        if (m > 65535) return 16'hFFFF;
        return m[15:0];
    endfunction

    function automatic logic [15:0] mean_s(input longint sum);
        longint m;
        m = sum >>> TOT;
        if (m > 32767)  return 16'h7FFF;
        if (m < -32768) return 16'h8000;
        return m[15:0];
    endfunction

    // Close a complete frame: compute the three means with plain arithmetic.
    task automatic close_frame(input longint due);
        longint s11 = 0, s22 = 0, s12 = 0;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            s11 += longint'(f1_q[i]) * f1_q[i];
            s22 += longint'(f2_q[i]) * f2_q[i];
            s12 += longint'(f1_q[i]) * f2_q[i];
        end
        e.r11 = mean_u(s11);
        e.r22 = mean_u(s22);
        e.r12 = mean_s(s12);
        e.due = due;
        exp_q.push_back(e);
        f1_q.delete();
        f2_q.delete();
    endtask

    // Drive one cycle of inputs and advance the reference model for the edge
    // that will sample them. A sample joins its frame two edges after capture;
    // sync drops anything that has not joined yet and restarts the frame.
    task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] b,
                         input bit sy, input bit rs);
        longint e;
        smp_t   s;
        @(negedge clk);
        #1;
        din_valid = v; din1 = a; din2 = b; sync = sy; rst = rs;
        e = cyc + 1;
        if (rs) begin
            pend_q.delete(); f1_q.delete(); f2_q.delete(); exp_q.delete();
            hold11 = 16'h0000; hold22 = 16'h0000; hold12 = 16'h0000;
        end else begin
            if (pend_q.size() > 0 && pend_q[0].commit == e) begin
                s = pend_q.pop_front();
                f1_q.push_back(s.x1);
                f2_q.push_back(s.x2);
                if (f1_q.size() == N) close_frame(e);
            end
            if (sy) begin
                pend_q.delete(); f1_q.delete(); f2_q.delete();
            end
            if (v) begin
                s.x1 = int'($signed(a));
                s.x2 = int'($signed(b));
                s.commit = e + 2;
                pend_q.push_back(s);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < N; i++) drive(1'b1, a, b, 1'b0, 1'b0);
    endtask

    // Monitor: pop and compare on every pulse, otherwise outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (dout_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: dout_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("r11", r11, e.r11);
                    chk("r22", r22, e.r22);
                    chk("r12", r12, e.r12);
                    chk_int("pulse_cycle", cyc, e.due);
                    hold11 = e.r11; hold22 = e.r22; hold12 = e.r12;
                end
            end else begin
                chk("dout_valid_low", {15'd0, dout_valid}, 16'h0000);
                chk("r11_hold", r11, hold11);
                chk("r22_hold", r22, hold22);
                chk("r12_hold", r12, hold12);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    chk_int("missing_pulse", 0, 1);
                end
            end
        end
    end

    initial begin
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("reset_r11", r11, 16'h0000);
        chk("reset_r22", r22, 16'h0000);
        chk("reset_r12", r12, 16'h0000);
        chk("reset_dv", {15'd0, dout_valid}, 16'h0000);
        mon_en = 1'b1;

        // 1..3: basic values, negative cross term, -1.0 saturation
        frame(16'h4000, 16'h4000); idle(4);
        frame(16'h4000, 16'hC000); idle(4);
        frame(16'h8000, 16'h8000); idle(4);

        // 4: valid every third cycle
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0);
            idle(2);
        end
        idle(4);

        // 5a: partial frame aborted by sync carrying sample 0
        drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        drive(1'b1, 16'h4000, 16'h4000, 1'b1, 1'b0);
        for (int i = 0; i < N - 1; i++) drive(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0);
        idle(4);

        // 5b: partial frame aborted by reset; outputs read zero until the pulse
        drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        frame(16'h4000, 16'h4000);
        idle(4);

        // 6: seamless back-to-back frames
        for (int k = 0; k < 4; k++) frame((k % 2 == 0) ? 16'h4000 : 16'h2000,
                                          (k % 2 == 0) ? 16'h4000 : 16'h2000);
        idle(4);

        // sync two edges after the last sample: frame still emitted
        frame(16'h2000, 16'hE000); idle(1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); idle(4);
        // sync one edge after the last sample: frame discarded
        frame(16'h6000, 16'h6000);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); idle(4);

        // random traffic with occasional sync and reset
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
                  ($urandom % 40) == 0, ($urandom % 300) == 0);
        end
        idle(8);

        chk_int("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
